// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline writeback / register-file slice.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int REG_IDX_W  = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file: one write port, two combinational read ports,
// r0 hardwired to zero, optional write-through bypass.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // we already excludes r0 and reset, so the bypass cannot leak either
    always_comb begin
        rdata_a = regs[raddr_a];
        if (BYPASS_EN && we && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
        if (raddr_a == REG_ZERO) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
        if (BYPASS_EN && we && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
        if (raddr_b == REG_ZERO) begin
            rdata_b = '0;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects link/load/ALU value, commits it to the register
// file and counts retired writes.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_to_reg,
    input  logic                 reg_write,
    input  logic                 link_en,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    link_data,
    input  logic [REG_IDX_W-1:0] dest_reg,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [REG_IDX_W-1:0] rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_fire,
    output logic [CNT_W-1:0]     wb_count
);

    wb_sel_e wb_sel;

    always_comb begin
        if (link_en) begin
            wb_sel = WB_SEL_LINK;
        end else if (mem_to_reg) begin
            wb_sel = WB_SEL_MEM;
        end else begin
            wb_sel = WB_SEL_ALU;
        end
    end

    always_comb begin
        case (wb_sel)
            WB_SEL_LINK: wb_data = link_data;
            WB_SEL_MEM:  wb_data = mem_data;
            default:     wb_data = alu_result;
        endcase
    end

    // Gating with rst_n keeps the bypass quiet while the array is held clear
    assign wb_fire = reg_write & (dest_reg != REG_ZERO) & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (wb_fire) begin
            wb_count <= wb_count + CNT_W'(1);
        end
    end

    regfile_2r1w #(
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_fire),
        .waddr   (dest_reg),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a default build (bypass, 32-bit count) and a
// no-bypass build with a 4-bit count, both driven by the same stimulus.
module tb_wb_regfile;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        mem_to_reg, reg_write, link_en;
    logic [31:0] mem_data, alu_result, link_data;
    logic [4:0]  dest_reg, rs_addr, rt_addr;

    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_fire;
    logic [31:0] wb_count;

    logic [31:0] rs_data_s, rt_data_s, wb_data_s;
    logic        wb_fire_s;
    logic [3:0]  wb_count_s;

    int tests;
    int fails;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .link_en(link_en), .mem_data(mem_data), .alu_result(alu_result),
        .link_data(link_data), .dest_reg(dest_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_fire(wb_fire),
        .wb_count(wb_count)
    );

    wb_regfile #(.DATA_W(32), .BYPASS_EN(1'b0), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .link_en(link_en), .mem_data(mem_data), .alu_result(alu_result),
        .link_data(link_data), .dest_reg(dest_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_s), .rt_data(rt_data_s), .wb_data(wb_data_s), .wb_fire(wb_fire_s),
        .wb_count(wb_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reg_write = 1'b1; dest_reg = 5'd4; alu_result = 32'h99;
        #2;
        tests++;
        if (wb_fire !== 1'b0) begin
            $display("FAIL reset_fire: got %b want 0", wb_fire); fails++;
        end
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            #1;
            tests++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0 || rs_data_s !== 32'h0) begin
                $display("FAIL reset_read[%0d]: got rs=%h rt=%h rs_s=%h want 0", i, rs_data, rt_data, rs_data_s);
                fails++;
            end
        end
        tests++;
        if (wb_count !== 32'd0 || wb_count_s !== 4'd0) begin
            $display("FAIL reset_count: got %0d/%0d want 0", wb_count, wb_count_s); fails++;
        end
        @(negedge clk);
        reg_write = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rs_addr = 5'd4; #1;
        tests++;
        if (rs_data !== 32'h0) begin
            $display("FAIL reset_nowrite: got %h want 0", rs_data); fails++;
        end
    endtask

    task automatic test_alu_bypass();
        reg_write = 1'b1; dest_reg = 5'd5; alu_result = 32'hDEADBEEF;
        mem_to_reg = 1'b0; link_en = 1'b0; rs_addr = 5'd5;
        #1;
        tests++;
        if (rs_data !== 32'hDEADBEEF || wb_fire !== 1'b1 || wb_data !== 32'hDEADBEEF) begin
            $display("FAIL alu_bypass: got rs=%h fire=%b wb=%h want deadbeef/1/deadbeef", rs_data, wb_fire, wb_data);
            fails++;
        end
        tests++;
        if (rs_data_s !== 32'h0) begin
            $display("FAIL nobypass_same_cycle: got %h want 0", rs_data_s); fails++;
        end
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        tests++;
        if (rs_data !== 32'hDEADBEEF || rs_data_s !== 32'hDEADBEEF) begin
            $display("FAIL alu_commit: got %h/%h want deadbeef", rs_data, rs_data_s); fails++;
        end
        tests++;
        if (wb_count !== 32'd1 || wb_count_s !== 4'd1) begin
            $display("FAIL alu_count: got %0d/%0d want 1", wb_count, wb_count_s); fails++;
        end
    endtask

    task automatic test_r0_write();
        reg_write = 1'b1; dest_reg = REG_ZERO; alu_result = 32'h12345678; rs_addr = 5'd0;
        #1;
        tests++;
        if (wb_fire !== 1'b0 || rs_data !== 32'h0 || wb_data !== 32'h12345678) begin
            $display("FAIL r0_before: got fire=%b rs=%h wb=%h want 0/0/12345678", wb_fire, rs_data, wb_data);
            fails++;
        end
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        tests++;
        if (rs_data !== 32'h0 || wb_count !== 32'd1) begin
            $display("FAIL r0_after: got rs=%h cnt=%0d want 0/1", rs_data, wb_count); fails++;
        end
    endtask

    task automatic test_link_priority();
        reg_write = 1'b1; dest_reg = REG_RA; link_en = 1'b1; mem_to_reg = 1'b1;
        link_data = 32'h00400008; mem_data = 32'hAAAA5555; rs_addr = REG_RA;
        #1;
        tests++;
        if (wb_data !== 32'h00400008) begin
            $display("FAIL link_mux: got %h want 00400008", wb_data); fails++;
        end
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        tests++;
        if (rs_data !== 32'h00400008 || rs_data_s !== 32'h00400008) begin
            $display("FAIL link_commit: got %h/%h want 00400008", rs_data, rs_data_s); fails++;
        end
        reg_write = 1'b1; link_en = 1'b0; #1;
        tests++;
        if (wb_data !== 32'hAAAA5555) begin
            $display("FAIL mem_mux: got %h want aaaa5555", wb_data); fails++;
        end
        @(posedge clk); #1;
        reg_write = 1'b0; mem_to_reg = 1'b0; #1;
        tests++;
        if (rs_data !== 32'hAAAA5555 || rs_data_s !== 32'hAAAA5555 || wb_count !== 32'd3) begin
            $display("FAIL mem_commit: got %h/%h cnt=%0d want aaaa5555 cnt=3", rs_data, rs_data_s, wb_count);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        reg_write = 1'b1; dest_reg = 5'd7; alu_result = 32'h1; rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        tests++;
        if (rs_data !== 32'h1 || rt_data !== 32'h1 || rs_data_s !== 32'h0) begin
            $display("FAIL b2b_cycle1: got %h/%h/%h want 1/1/0", rs_data, rt_data, rs_data_s); fails++;
        end
        @(posedge clk); #1;
        alu_result = 32'h2; #1;
        tests++;
        if (rs_data !== 32'h2 || rt_data !== 32'h2 || rt_data_s !== 32'h1) begin
            $display("FAIL b2b_cycle2: got %h/%h/%h want 2/2/1", rs_data, rt_data, rt_data_s); fails++;
        end
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        tests++;
        if (rs_data !== 32'h2 || rs_data_s !== 32'h2 || rt_data_s !== 32'h2 || wb_count !== 32'd5) begin
            $display("FAIL b2b_after: got %h/%h/%h cnt=%0d want 2 cnt=5", rs_data, rs_data_s, rt_data_s, wb_count);
            fails++;
        end
    endtask

    task automatic test_async_reset();
        reg_write = 1'b1; dest_reg = 5'd3; alu_result = 32'h55; rs_addr = 5'd3;
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        tests++;
        if (rs_data !== 32'h55) begin
            $display("FAIL fill_r3: got %h want 55", rs_data); fails++;
        end
        #2;
        rst_n = 1'b0;
        reg_write = 1'b1; alu_result = 32'h77;
        #1;
        tests++;
        if (rs_data !== 32'h0 || rs_data_s !== 32'h0 || wb_fire !== 1'b0 || wb_count !== 32'd0) begin
            $display("FAIL async_clear: got rs=%h rs_s=%h fire=%b cnt=%0d want 0", rs_data, rs_data_s, wb_fire, wb_count);
            fails++;
        end
        reg_write = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rs_data !== 32'h0 || wb_count !== 32'd0) begin
            $display("FAIL async_after: got rs=%h cnt=%0d want 0", rs_data, wb_count); fails++;
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 1; i <= 15; i++) begin
            reg_write = 1'b1; dest_reg = 5'(i); alu_result = 32'(i * 17);
            @(posedge clk); #1;
        end
        reg_write = 1'b0; rs_addr = 5'd15; rt_addr = 5'd9; #1;
        tests++;
        if (wb_count_s !== 4'hF || wb_count !== 32'd15) begin
            $display("FAIL wrap_pre: got %0d/%0d want 15/15", wb_count_s, wb_count); fails++;
        end
        tests++;
        if (rs_data_s !== 32'd255 || rt_data !== 32'd153) begin
            $display("FAIL fill_regs: got %0d/%0d want 255/153", rs_data_s, rt_data); fails++;
        end
        reg_write = 1'b1; dest_reg = 5'd1; alu_result = 32'hABC;
        @(posedge clk); #1;
        reg_write = 1'b0; #1;
        tests++;
        if (wb_count_s !== 4'h0 || wb_count !== 32'd16) begin
            $display("FAIL wrap: got %0d/%0d want 0/16", wb_count_s, wb_count); fails++;
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        mem_to_reg = 1'b0; reg_write = 1'b0; link_en = 1'b0;
        mem_data = '0; alu_result = '0; link_data = '0;
        dest_reg = '0; rs_addr = '0; rt_addr = '0;
        test_reset();
        test_alu_bypass();
        test_r0_write();
        test_link_priority();
        test_back_to_back();
        test_async_reset();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback stage and architectural register file for the 5-stage MIPS pipeline. It sits directly downstream of the MEM/WB pipeline register. It selects the writeback value (link, load data or ALU result) and commits it to a 32x32 register file on the clock edge. It serves the two combinational ID-stage read ports, with internal write-through bypass, because the pipeline has no forwarding unit.

Parameters:
DATA_W, 32, register and datapath width in bits
BYPASS_EN, 1, 1 = same-cycle WB->read bypass enabled; 0 = reads return stored array contents only
CNT_W, 32, width of retired-write counter

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_to_reg  input  1  select load data for writeback
reg_write  input  1  commit writeback this cycle
link_en  input  1  select link data (JAL/JALR return address), overrides mem_to_reg
mem_data  input  DATA_W  load data from MEM/WB
alu_result  input  DATA_W  ALU result from MEM/WB
link_data  input  DATA_W  PC+8 link value from MEM/WB
dest_reg  input  5  destination register index
rs_addr  input  5  read port A index (ID stage)
rt_addr  input  5  read port B index (ID stage)
rs_data  output  DATA_W  read port A data, combinational
rt_data  output  DATA_W  read port B data, combinational
wb_data  output  DATA_W  selected writeback value, combinational (debug/trace)
wb_fire  output  1  high when a write to a non-zero register commits this cycle
wb_count  output  CNT_W  registered count of committed writes

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, all 32 registers = 0, wb_count = 0, and rs_data/rt_data = 0 with bypass suppressed. No write occurs on an edge where rst_n=0. The first write is accepted on the first rising edge after deassertion. Reset asserted mid-stream discards any in-flight writeback.
- Writeback mux (combinational), priority order:
  - link_en=1 -> link_data
  - else mem_to_reg=1 -> mem_data
  - else -> alu_result
  - wb_data always shows the mux result, regardless of reg_write.
- wb_fire = reg_write & (dest_reg != 0) & rst_n.
- Commit: on a rising edge with wb_fire=1, reg[dest_reg] <= wb_data and wb_count <= wb_count+1. Latency is 1 edge into the array.
- Register 0: hardwired zero. A write with dest_reg=0 is dropped, does not increment wb_count, and reads of index 0 always return 0.
- Reads are combinational from the array.
- With BYPASS_EN=1, if wb_fire=1 and a read address == dest_reg, that port returns wb_data in the same cycle (write-before-read semantics). Both ports bypass independently, including when rs_addr == rt_addr == dest_reg.
- With BYPASS_EN=0, the new value is visible from the cycle after the commit edge.
- wb_count wraps modulo 2^CNT_W with no saturation and no flag.
- Undefined control combinations (e.g. link_en and mem_to_reg both 1) resolve by the priority above; no assertion fires.

Decomposition:
- Shared package mips_pkg: DATA_W default, REG_IDX_W=5, NUM_REGS=32, constant REG_ZERO=5'd0, constant REG_RA=5'd31.
- One sub-module is natural: regfile_2r1w (array, async reset clear, r0 masking, bypass mux). The writeback mux and wb_count stay in wb_regfile.

Test Plan:
- Reset then read all 32 indices on both ports -> all return 0; wb_count=0.
- reg_write=1, dest=5, mem_to_reg=0, link_en=0, alu_result=0xDEADBEEF; same cycle rs_addr=5 -> rs_data=0xDEADBEEF (bypass); next cycle, with reg_write=0, still 0xDEADBEEF; wb_count=1.
- reg_write=1, dest=0, alu_result=0x12345678 -> wb_fire=0, rs_addr=0 reads 0 before and after the edge, wb_count unchanged.
- link_en=1 and mem_to_reg=1, link_data=0x00400008, mem_data=0xAAAA5555, dest=31 -> reg31=0x00400008; with link_en=0 and mem_to_reg=1 -> reg31=0xAAAA5555.
- Back-to-back writes dest=7 with 0x1 then 0x2, rs_addr=rt_addr=7 -> both ports show 0x1 in cycle 1 and 0x2 in cycle 2; wb_count advances by 2.
- Fill reg3=0x55, pulse rst_n low asynchronously between edges -> rs_data(3) drops to 0 immediately and stays 0 after release; preload wb_count to all-ones (CNT_W=4 build) and commit one write -> wraps to 0.
